// File: rtl/axi_param_timer.sv
// Free-running timebase with stop limit, self-clearing CLEAR and compare alarms behind AXI4-Lite.
// Writes land on the AW/W handshake edge, reads return one cycle after AR; one outstanding write and read each.
module axi_param_timer #(
    parameter int TIME_WIDTH = 64,
    parameter int NUM_ALARMS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [TIME_WIDTH-1:0] current_time,
    output logic                  time_running,
    output logic [NUM_ALARMS-1:0] alarm,
    input  logic [11:0]           s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [11:0]           s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);
    localparam int TW = TIME_WIDTH;

    logic [TW-1:0]         cnt, cnt_inc, cnt_nxt, max_val;
    logic [TW-1:0]         alarm_val [NUM_ALARMS];
    logic [63:0]           cnt64, max64;
    logic [63:0]           alarm64 [NUM_ALARMS];
    logic                  enable, running, inc, clear_now;
    logic [NUM_ALARMS-1:0] alarm_en, alarm_flag, alarm_nxt, flag_clr;
    logic                  wr_rdy, wr_en, bvld, ar_rdy, rd_en, rvld;
    logic [1:0]            bresp, rresp;
    logic [31:0]           shadow_hi, rd_dat, rdata;
    logic [9:0]            wr_idx, rd_idx;
    logic                  unused_bits;

    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
    assign wr_idx = s_axi_awaddr[11:2];
    assign rd_idx = s_axi_araddr[11:2];
    assign cnt64  = 64'(cnt);
    assign max64  = 64'(max_val);

    function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [31:0] dat,
                                             input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = dat[8*b +: 8];
        return r;
    endfunction

    function automatic logic mapped(input logic [9:0] idx);
        return (idx <= 10'd5) || (idx >= 10'd8 && idx < 10'(8 + 2*NUM_ALARMS));
    endfunction

    // Increment is gated by the limit directly so a late-dropping running flag never overshoots MAX.
    always_comb begin
        inc       = running && enable && (cnt < max_val);
        clear_now = wr_en && (wr_idx == 10'd0) && s_axi_wstrb[0] && s_axi_wdata[1];
        cnt_inc   = cnt + TW'(1);
        cnt_nxt   = clear_now ? '0 : (inc ? cnt_inc : cnt);
        flag_clr  = (wr_en && wr_idx == 10'd1 && s_axi_wstrb[1]) ? s_axi_wdata[8 +: NUM_ALARMS] : '0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            alarm_nxt[k] = !clear_now && inc && alarm_en[k] && (cnt_inc == alarm_val[k]);
            alarm64[k]   = 64'(alarm_val[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            running    <= 1'b0;
            alarm      <= '0;
            enable     <= 1'b0;
            alarm_en   <= '0;
            alarm_flag <= '0;
            max_val    <= '1;
            for (int k = 0; k < NUM_ALARMS; k++) alarm_val[k] <= '0;
        end else begin
            cnt        <= cnt_nxt;
            running    <= enable && (cnt_nxt < max_val);
            alarm      <= alarm_nxt;
            alarm_flag <= (alarm_flag & ~flag_clr) | alarm_nxt;
            if (wr_en) begin
                if (wr_idx == 10'd0) begin
                    if (s_axi_wstrb[0]) enable   <= s_axi_wdata[0];
                    if (s_axi_wstrb[1]) alarm_en <= s_axi_wdata[8 +: NUM_ALARMS];
                end
                if (wr_idx == 10'd2)
                    max_val <= TW'({max64[63:32], wr_merge(max64[31:0], s_axi_wdata, s_axi_wstrb)});
                if (wr_idx == 10'd3)
                    max_val <= TW'({wr_merge(max64[63:32], s_axi_wdata, s_axi_wstrb), max64[31:0]});
                for (int k = 0; k < NUM_ALARMS; k++) begin
                    if (wr_idx == 10'(8 + 2*k))
                        alarm_val[k] <= TW'({alarm64[k][63:32],
                                             wr_merge(alarm64[k][31:0], s_axi_wdata, s_axi_wstrb)});
                    if (wr_idx == 10'(9 + 2*k))
                        alarm_val[k] <= TW'({wr_merge(alarm64[k][63:32], s_axi_wdata, s_axi_wstrb),
                                             alarm64[k][31:0]});
                end
            end
        end
    end

    // Ready is only raised once both AW and W are present and the previous response is draining.
    assign wr_en = wr_rdy && s_axi_awvalid && s_axi_wvalid;
    assign rd_en = ar_rdy && s_axi_arvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_rdy    <= 1'b0;
            bvld      <= 1'b0;
            bresp     <= 2'b00;
            ar_rdy    <= 1'b0;
            rvld      <= 1'b0;
            rresp     <= 2'b00;
            rdata     <= '0;
            shadow_hi <= '0;
        end else begin
            wr_rdy <= s_axi_awvalid && s_axi_wvalid && !wr_rdy && !(bvld && !s_axi_bready);
            if (wr_en) begin
                bvld  <= 1'b1;
                bresp <= mapped(wr_idx) ? 2'b00 : 2'b10;
            end else if (s_axi_bready) begin
                bvld  <= 1'b0;
            end
            ar_rdy <= s_axi_arvalid && !ar_rdy && !(rvld && !s_axi_rready);
            if (rd_en) begin
                rvld  <= 1'b1;
                rdata <= rd_dat;
                rresp <= mapped(rd_idx) ? 2'b00 : 2'b10;
                if (rd_idx == 10'd4) shadow_hi <= cnt64[63:32];
            end else if (s_axi_rready) begin
                rvld  <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        case (rd_idx)
            10'd0: begin
                rd_dat[0]               = enable;
                rd_dat[8 +: NUM_ALARMS] = alarm_en;
            end
            10'd1: begin
                rd_dat[0]               = running;
                rd_dat[8 +: NUM_ALARMS] = alarm_flag;
            end
            10'd2:   rd_dat = max64[31:0];
            10'd3:   rd_dat = max64[63:32];
            10'd4:   rd_dat = cnt64[31:0];
            10'd5:   rd_dat = shadow_hi;
            default: begin
                for (int k = 0; k < NUM_ALARMS; k++) begin
                    if (rd_idx == 10'(8 + 2*k)) rd_dat = alarm64[k][31:0];
                    if (rd_idx == 10'(9 + 2*k)) rd_dat = alarm64[k][63:32];
                end
            end
        endcase
    end

    assign current_time  = cnt;
    assign time_running  = running;
    assign s_axi_awready = wr_rdy;
    assign s_axi_wready  = wr_rdy;
    assign s_axi_bvalid  = bvld;
    assign s_axi_bresp   = bresp;
    assign s_axi_arready = ar_rdy;
    assign s_axi_rvalid  = rvld;
    assign s_axi_rdata   = rdata;
    assign s_axi_rresp   = rresp;
endmodule

// File: tb/tb_axi_param_timer.sv
// Directed bench for axi_param_timer: enable, stop limit, alarms, CLEAR, coherent read, AXI corner cases.
module tb_axi_param_timer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] current_time;
    logic        time_running;
    logic [1:0]  alarm;
    logic [11:0] s_axi_awaddr = '0, s_axi_araddr = '0;
    logic [2:0]  s_axi_awprot = '0, s_axi_arprot = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b1;
    logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [31:0] s_axi_wdata = '0, s_axi_rdata;
    logic [3:0]  s_axi_wstrb = '0;
    logic [1:0]  s_axi_bresp, s_axi_rresp;

    always #5 clk = ~clk;

    axi_param_timer dut (
        .clk(clk), .rst_n(rst_n), .current_time(current_time), .time_running(time_running),
        .alarm(alarm),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Pulse and zero-landing monitor, cleared by mon_clr.
    logic        mon_clr = 1'b1;
    int          a0_cnt, a1_cnt;
    logic [63:0] a0_val;
    logic        saw_zero;
    always @(negedge clk) begin
        if (mon_clr) begin
            a0_cnt = 0; a1_cnt = 0; a0_val = '0; saw_zero = 1'b0;
        end else begin
            if (alarm[0]) begin a0_cnt++; a0_val = current_time; end
            if (alarm[1]) a1_cnt++;
            if (current_time == 64'd0) saw_zero = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [63:0] obs, input logic [63:0] lo,
                           input logic [63:0] hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h..%0h", tag, obs, lo, hi);
        end
    endtask

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1;
        for (int i = 0; i < lead; i++) begin
            @(negedge clk);
            chk("aw_early_ready", 64'({s_axi_awready, s_axi_wready}), 0);
        end
        s_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axi_awready && n < 20) begin @(negedge clk); n++; end
        chk("aw_w_ready", 64'({s_axi_awready, s_axi_wready}), 3);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
        chk("bvalid", 64'(s_axi_bvalid), 1);
        resp = s_axi_bresp;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_single", 64'(s_axi_bvalid), 0);
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold, output logic [31:0] d,
                            output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
        chk("ar_ready", 64'(s_axi_arready), 1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
        chk("rvalid", 64'(s_axi_rvalid), 1);
        d = s_axi_rdata;
        resp = s_axi_rresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("r_hold_data", 64'({s_axi_rvalid, s_axi_rdata}), 64'({1'b1, d}));
        end
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        @(negedge clk);
        chk("r_single", 64'(s_axi_rvalid), 0);
    endtask

    task automatic wait_run(input logic lvl, input int lim, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (time_running !== lvl && n < lim) begin @(negedge clk); n++; end
        chk(tag, 64'(time_running), 64'(lvl));
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] d, lo, hi;
        logic [1:0]  r;
        logic [63:0] t;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_time", current_time, 0);
        chk("rst_running", 64'(time_running), 0);
        chk("rst_alarm", 64'(alarm), 0);
        chk("rst_handshakes", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid}), 0);
        rst_n = 1'b1;
        axi_read(12'h008, 0, d, r); chk("max_lo_rst", 64'(d), 64'hFFFF_FFFF);
        axi_read(12'h00C, 0, d, r); chk("max_hi_rst", 64'(d), 64'hFFFF_FFFF);
        axi_read(12'h000, 0, d, r); chk("cfg_rst", 64'(d), 0);

        // Enable from reset: 10 cycles after running rises
        axi_write(12'h000, 32'h1, 4'hF, 0, r);
        chk("cfg_bresp", 64'(r), 0);
        wait_run(1'b1, 20, "run_rise");
        repeat (10) @(posedge clk);
        axi_read(12'h010, 0, d, r); chk_rng("enable_time_lo", 64'(d), 10, 14);
        chk("time_lo_rresp", 64'(r), 0);
        axi_read(12'h014, 0, d, r); chk("enable_time_hi", 64'(d), 0);

        // Stop limit at 5
        do_reset();
        axi_write(12'h008, 32'd5, 4'hF, 0, r);
        axi_write(12'h00C, 32'd0, 4'hF, 0, r);
        axi_write(12'h000, 32'h1, 4'hF, 0, r);
        wait_run(1'b1, 20, "stop_run_rise");
        wait_run(1'b0, 40, "stop_run_fall");
        chk("stop_value", current_time, 5);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stop_hold", current_time, 5);
        end
        chk("stop_running_low", 64'(time_running), 0);
        axi_read(12'h004, 0, d, r); chk("stop_status", 64'(d), 0);

        // Alarms: both compare at 7, only channel 0 enabled
        do_reset();
        axi_write(12'h020, 32'd7, 4'hF, 0, r);
        axi_write(12'h028, 32'd7, 4'hF, 0, r);
        @(posedge clk); #1; mon_clr = 1'b0;
        axi_write(12'h000, 32'h101, 4'hF, 0, r);
        repeat (20) @(negedge clk);
        chk("alarm0_pulses", 64'(a0_cnt), 1);
        chk("alarm0_time", a0_val, 7);
        chk("alarm1_pulses", 64'(a1_cnt), 0);
        axi_read(12'h004, 0, d, r); chk("status_flag", 64'(d), 64'h101);
        axi_write(12'h004, 32'h100, 4'b0010, 0, r);
        axi_read(12'h004, 0, d, r); chk("status_w1c", 64'(d), 64'h001);

        // CLEAR while running with alarm 0 armed at 0
        axi_write(12'h020, 32'd0, 4'hF, 0, r);
        @(posedge clk); #1; mon_clr = 1'b1;
        @(posedge clk); #1; mon_clr = 1'b0;
        axi_write(12'h000, 32'h103, 4'hF, 0, r);
        repeat (5) @(negedge clk);
        chk("clear_saw_zero", 64'(saw_zero), 1);
        chk("clear_no_alarm", 64'(a0_cnt), 0);
        chk("clear_running", 64'(time_running), 1);
        chk_rng("clear_resume", current_time, 4, 7);
        axi_read(12'h000, 0, d, r); chk("cfg_clear_reads0", 64'(d), 64'h101);

        // MAX written below the current time stops the counter at once
        axi_write(12'h00C, 32'd0, 4'hF, 0, r);
        axi_write(12'h008, 32'd3, 4'hF, 0, r);
        @(negedge clk);
        t = current_time;
        repeat (5) @(negedge clk);
        chk("max_below_hold", current_time, t);
        chk("max_below_running", 64'(time_running), 0);

        // Coherent LO/HI read across the 32-bit carry
        do_reset();
        axi_write(12'h000, 32'h1, 4'hF, 0, r);
        @(negedge clk);
        force dut.cnt = 64'hFFFF_FFF0;
        @(negedge clk);
        release dut.cnt;
        for (int i = 0; i < 5; i++) begin
            axi_read(12'h010, 0, lo, r);
            axi_read(12'h014, 0, hi, r);
            chk_rng("coherent_pair", {hi, lo}, 64'hFFFF_FFF0, 64'h1_0000_0100);
        end
        chk("carry_hi", 64'(hi), 1);

        // AXI robustness
        axi_write(12'h028, 32'h1234, 4'hF, 3, r);
        chk("aw_lead_bresp", 64'(r), 0);
        axi_read(12'h028, 5, d, r);
        chk("delayed_read_data", 64'(d), 64'h1234);
        chk("delayed_read_rresp", 64'(r), 0);
        axi_write(12'h028, 32'hAABB_CCDD, 4'b0010, 0, r);
        axi_read(12'h028, 0, d, r); chk("wstrb_byte1", 64'(d), 64'hCC34);
        axi_write(12'h0FC, 32'hFFFF_FFFF, 4'hF, 0, r); chk("unmapped_bresp", 64'(r), 2);
        axi_read(12'h0FC, 0, d, r); chk("unmapped_rresp", 64'(r), 2);
        axi_write(12'h030, 32'h5, 4'hF, 0, r); chk("alarm2_bresp", 64'(r), 2);
        axi_write(12'h000, 32'hFFFF_FFFE, 4'hF, 0, r);
        axi_read(12'h000, 0, d, r); chk("cfg_unused_bits", 64'(d), 64'h300);

        // Reset in the middle of a read
        axi_write(12'h000, 32'h1, 4'hF, 0, r);
        @(posedge clk); #1;
        s_axi_araddr = 12'h010; s_axi_arvalid = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_time", current_time, 0);
        chk("midrst_flags", 64'({time_running, s_axi_arready, s_axi_rvalid, s_axi_bvalid}), 0);
        s_axi_arvalid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        axi_read(12'h000, 0, d, r); chk("midrst_cfg", 64'(d), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_param_timer.md
# axi_param_timer

Parametrised free-running timebase with AXI4-Lite control, the next generation of the single 64-bit system timer. Adds configurable counter width, a programmable stop limit, a self-clearing counter clear and NUM_ALARMS compare channels with pulse outputs and sticky status flags. It sits beside the PS interconnect and distributes `current_time` and `time_running` to the measurement cores.

## Interface

- `TIME_WIDTH`, 64, counter width; legal range 32..64.
- `NUM_ALARMS`, 2, number of compare channels; legal range 1..4.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous, active-low. `clk` is the only clock.
- `current_time`  out  TIME_WIDTH  counter value.
- `time_running`  out  1  high while the counter is incrementing.
- `alarm`  out  NUM_ALARMS  one-cycle pulse per channel on compare match.
- `s_axi_awaddr`/`s_axi_araddr`  in  12  byte addresses.
- `s_axi_awprot`/`s_axi_arprot`  in  3  ignored.
- `s_axi_awvalid`, `s_axi_awready`, `s_axi_wvalid`, `s_axi_wready`, `s_axi_bvalid`, `s_axi_bready`, `s_axi_arvalid`, `s_axi_arready`, `s_axi_rvalid`, `s_axi_rready`  1  standard AXI4-Lite handshakes.
- `s_axi_wdata`/`s_axi_rdata`  in/out  32  data.
- `s_axi_wstrb`  in  4  byte enables.
- `s_axi_bresp`/`s_axi_rresp`  out  2  responses.

## Operation

- Register map (32-bit words, `addr[11:2]` decoded):
  - 0x00 CFG (RW).
    - bit0 ENABLE.
    - bit1 CLEAR: write-1 self-clearing, reads 0.
    - bits[8+k] ALARM_EN[k].
  - 0x04 STATUS.
    - bit0 RUNNING (RO).
    - bits[8+k] ALARM_FLAG[k]: write-1-to-clear.
  - 0x08/0x0C MAX_LO/MAX_HI (RW).
  - 0x10/0x14 TIME_LO/TIME_HI (RO).
  - 0x20+8k / 0x24+8k ALARMk_LO/HI (RW).
- Reset values:
  - All registers and outputs 0, except MAX, which resets to all-ones.
  - `s_axi_*ready`, `bvalid` and `rvalid` reset to 0.
- Bits above TIME_WIDTH in any HI register read 0 and ignore writes. Unused CFG/STATUS bits read 0.
- `time_running` = ENABLE && (`current_time` < MAX), registered.
- While `time_running` is high, `current_time` increments by 1 per clk.
- Saturation:
  - On reaching MAX the counter holds and `time_running` drops.
  - Writing MAX ≤ current time stops the counter immediately.
  - The counter never wraps.
- CLEAR loads 0. If CLEAR coincides with an increment, CLEAR wins.
- Alarm k fires when the counter steps to a value equal to ALARMk with ALARM_EN[k] set:
  - `alarm[k]` is high for exactly the cycle in which `current_time` == ALARMk.
  - ALARM_FLAG[k] is set.
  - A holding counter, or a CLEAR landing on ALARMk = 0, does not re-fire.
  - If a flag set and a W1C clear occur in the same cycle, the set wins.
- Coherent 64-bit read: reading TIME_LO latches the current upper bits into a shadow register, and TIME_HI returns the shadow. Software reads LO first.
- Writes:
  - AW and W must both be valid before either ready asserts. `awready`/`wready` pulse together for one cycle.
  - `wstrb` is applied per byte.
  - Writes to RO or unmapped addresses change nothing.
  - Only one outstanding write. A new write is not accepted while `bvalid` is high.
- Reads:
  - `arready` pulses when `arvalid` is high and `rvalid` is low.
  - Only one outstanding read.
  - `rdata` is held stable until `rready`.
- Responses: OKAY (00) for mapped addresses, SLVERR (10) for unmapped addresses, including alarm windows beyond NUM_ALARMS.
- Reset mid-operation: all state returns to its reset values immediately. Any in-flight response is dropped.

## Timing

- Write path:
  - The register updates on the edge where `awready`/`wready` are high.
  - `bvalid` rises on the following edge and stays high until `bready`.
- Read path: `rvalid` rises one cycle after the AR handshake. The TIME_LO snapshot is taken on the AR handshake edge.
- Enable latency: the ENABLE write edge is N, `time_running` rises at N+1, and `current_time` is 1 at N+2.
- CLEAR latency: `current_time` is 0 on the cycle after the write edge.
- Alarm latency: `alarm[k]` is combinationally coincident with the matching counter value, driven by a register with no extra latency. The flag is visible in STATUS from the next cycle.
- Throughput: one write per 2 cycles minimum, and one read per 2 cycles.

## Test plan

- Enable from reset:
  - Stimulus: reset, write CFG = 0x1, run 10 cycles after `time_running` rises.
  - Required response: TIME_LO reads 10 ± the read latency, TIME_HI reads 0, and `bresp` = 00.
- Stop limit:
  - Stimulus: MAX = 5, enable.
  - Required response: the counter stops at 5, `time_running` goes 0, STATUS.RUNNING = 0, and the counter is held for 20 cycles.
- Alarms:
  - Stimulus: ALARM0 = 7, ALARM1 = 7, ALARM_EN = 0b01, enable.
  - Required response: a single `alarm[0]` pulse when the time equals 7, no `alarm[1]` pulse, and STATUS = 0x101 while running.
  - Stimulus: W1C with 0x100.
  - Required response: the flag clears.
- CLEAR collision:
  - Stimulus: with the counter running, write CLEAR.
  - Required response: the next value is 0, counting resumes, and an alarm at 0 does not fire.
- Coherent read across the 32-bit carry:
  - Stimulus: TIME_WIDTH = 64, counter crossing 0xFFFF_FFFF.
  - Required response: the LO-then-HI pair is consistent (never HI = 1 with a stale LO).
- AXI robustness:
  - Stimulus: AW 3 cycles before W. Separately, a write to 0x0FC. Separately, a read with `rready` held low for 5 cycles, then high.
  - Required response: the AW-before-W write is accepted once both are valid, with one response. The write to 0x0FC gets SLVERR. The delayed read holds stable `rdata` and is followed by exactly one response.
